// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp and a level MTIP
// interrupt, reached through a single-cycle request/ack data-bus port.
module machine_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_be,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        timer_irq
);

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_CTRL        = 3'd4,
        REG_RSVD5       = 3'd5,
        REG_RSVD6       = 3'd6,
        REG_RSVD7       = 3'd7
    } reg_sel_e;

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] mtime_hi_shadow;
    logic [15:0] presc_cnt;
    logic        en;

    reg_sel_e    sel;
    logic        wr;
    logic        rd;
    logic        mtime_wr;
    logic        tick;
    logic [63:0] mtime_wval;
    logic [31:0] rdata_next;

    // Byte offset bits below the word index carry no meaning in this map.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus_addr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign sel      = reg_sel_e'(bus_addr[4:2]);
    assign wr       = bus_req & bus_we;
    assign rd       = bus_req & ~bus_we;
    assign mtime_wr = wr & ((sel == REG_MTIME_LO) | (sel == REG_MTIME_HI));
    assign tick     = en & (presc_cnt == PRESCALE_LAST);

    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mtime_wval = mtime;
        if (wr && sel == REG_MTIME_LO) mtime_wval[31:0]  = merge_bytes(mtime[31:0], bus_wdata, bus_be);
        if (wr && sel == REG_MTIME_HI) mtime_wval[63:32] = merge_bytes(mtime[63:32], bus_wdata, bus_be);
    end

    always_comb begin
        rdata_next = '0;
        unique case (sel)
            REG_MTIME_LO:    rdata_next = mtime[31:0];
            REG_MTIME_HI:    rdata_next = mtime_hi_shadow;
            REG_MTIMECMP_LO: rdata_next = mtimecmp[31:0];
            REG_MTIMECMP_HI: rdata_next = mtimecmp[63:32];
            REG_CTRL:        rdata_next = {30'd0, timer_irq, en};
            default:         rdata_next = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime           <= '0;
            mtimecmp        <= '1;
            mtime_hi_shadow <= '0;
            presc_cnt       <= '0;
            en              <= 1'b1;
            bus_ack         <= 1'b0;
            bus_rdata       <= '0;
            timer_irq       <= 1'b0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= rd ? rdata_next : '0;
            timer_irq <= (mtime >= mtimecmp);

            // A software write to mtime beats a same-cycle tick and restarts the prescaler.
            if (mtime_wr) begin
                mtime           <= mtime_wval;
                presc_cnt       <= '0;
                mtime_hi_shadow <= mtime_wval[63:32];
            end else begin
                if (tick) begin
                    mtime     <= mtime + 64'd1;
                    presc_cnt <= '0;
                end else if (en) begin
                    presc_cnt <= presc_cnt + 16'd1;
                end
                if (rd && sel == REG_MTIME_LO) mtime_hi_shadow <= mtime[63:32];
            end

            if (wr && sel == REG_MTIMECMP_LO) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], bus_wdata, bus_be);
            if (wr && sel == REG_MTIMECMP_HI) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus_wdata, bus_be);
            if (wr && sel == REG_CTRL && bus_be[0]) en <= bus_wdata[0];
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model of the register map.
module tb_machine_timer;

    localparam int unsigned P = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        timer_irq;

    machine_timer #(.PRESCALE(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: time advances by one per P enabled cycles.
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic        m_en;
    int          m_phase;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        m_irq;

    typedef struct {
        logic        req;
        logic        we;
        logic [2:0]  word;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
        return r;
    endfunction

    task automatic model_step(input logic r, input logic req, input logic we, input logic [2:0] word,
                              input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] rd;
        logic [63:0] t;
        logic        irq_n;
        if (r) begin
            m_time = '0; m_cmp = '1; m_shadow = '0; m_en = 1'b1; m_phase = 0;
            m_ack = 1'b0; m_rdata = '0; m_irq = 1'b0;
            return;
        end
        rd = '0;
        if (req && !we) begin
            case (word)
                3'd0: rd = m_time[31:0];
                3'd1: rd = m_shadow;
                3'd2: rd = m_cmp[31:0];
                3'd3: rd = m_cmp[63:32];
                3'd4: rd = {30'd0, m_irq, m_en};
                default: rd = '0;
            endcase
        end
        irq_n = (m_time >= m_cmp);
        if (req && we && word <= 3'd1) begin
            t = m_time;
            if (word == 3'd0) t[31:0]  = merge(t[31:0], wd, be);
            else              t[63:32] = merge(t[63:32], wd, be);
            m_time = t; m_phase = 0; m_shadow = t[63:32];
        end else begin
            if (req && !we && word == 3'd0) m_shadow = m_time[63:32];
            if (m_en) begin
                m_phase = (m_phase + 1) % P;
                if (m_phase == 0) m_time = m_time + 1;
            end
        end
        if (req && we && word == 3'd2) m_cmp[31:0]  = merge(m_cmp[31:0], wd, be);
        if (req && we && word == 3'd3) m_cmp[63:32] = merge(m_cmp[63:32], wd, be);
        if (req && we && word == 3'd4 && be[0]) m_en = wd[0];
        m_ack = req; m_rdata = rd; m_irq = irq_n;
    endtask

    task automatic drive(input logic r, input logic req, input logic we, input logic [2:0] word,
                         input logic [31:0] wd, input logic [3:0] be);
        rst = r; bus_req = req; bus_we = we;
        bus_addr = {word, 2'($urandom_range(0, 3))};
        bus_wdata = wd; bus_be = be;
        model_step(r, req, we, word, wd, be);
        @(posedge clk);
        #1;
        check("model_ack", {63'd0, bus_ack}, {63'd0, m_ack});
        check("model_rdata", {32'd0, bus_rdata}, {32'd0, m_rdata});
        check("model_irq", {63'd0, timer_irq}, {63'd0, m_irq});
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [2:0] word, input logic [31:0] wd, input logic [3:0] be);
        drive(1'b0, 1'b1, 1'b1, word, wd, be);
    endtask

    task automatic rd(input logic [2:0] word);
        drive(1'b0, 1'b1, 1'b0, word, 32'd0, 4'd0);
    endtask

    function automatic vec_t mk(input logic req, input logic we, input logic [2:0] word,
                                input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp);
        vec_t v;
        v.req = req; v.we = we; v.word = word; v.wdata = wd; v.be = be;
        v.exp_ack = req; v.exp_rdata = exp;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t20;
        int rise;

        vecs[0]  = mk(1, 0, 3'd2, 32'h0,        4'h0, 32'hFFFF_FFFF);
        vecs[1]  = mk(1, 0, 3'd3, 32'h0,        4'h0, 32'hFFFF_FFFF);
        vecs[2]  = mk(1, 0, 3'd4, 32'h0,        4'h0, 32'h1);
        vecs[3]  = mk(1, 0, 3'd5, 32'h0,        4'h0, 32'h0);
        vecs[4]  = mk(1, 0, 3'd7, 32'h0,        4'h0, 32'h0);
        vecs[5]  = mk(1, 1, 3'd4, 32'h0,        4'h1, 32'h0);
        vecs[6]  = mk(1, 1, 3'd0, 32'hAAAA_AAAA, 4'hF, 32'h0);
        vecs[7]  = mk(1, 1, 3'd0, 32'h1234_5678, 4'h3, 32'h0);
        vecs[8]  = mk(1, 0, 3'd0, 32'h0,        4'h0, 32'hAAAA_5678);
        vecs[9]  = mk(1, 0, 3'd1, 32'h0,        4'h0, 32'h0);
        vecs[10] = mk(1, 1, 3'd1, 32'hDEAD_BEEF, 4'hF, 32'h0);
        vecs[11] = mk(1, 0, 3'd1, 32'h0,        4'h0, 32'hDEAD_BEEF);
        vecs[12] = mk(1, 0, 3'd0, 32'h0,        4'h0, 32'hAAAA_5678);
        vecs[13] = mk(1, 1, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0);
        vecs[14] = mk(1, 0, 3'd6, 32'h0,        4'h0, 32'h0);
        vecs[15] = mk(1, 1, 3'd4, 32'h1,        4'h0, 32'h0);
        vecs[16] = mk(1, 0, 3'd4, 32'h0,        4'h0, 32'h0);
        vecs[17] = mk(1, 1, 3'd4, 32'h1,        4'h1, 32'h0);
        vecs[18] = mk(1, 0, 3'd4, 32'h0,        4'h0, 32'h1);

        // Reset state, then free-run: 40 enabled cycles at PRESCALE=4 gives mtime = 10.
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
        check("reset_ack", {63'd0, bus_ack}, 64'd0);
        check("reset_irq", {63'd0, timer_irq}, 64'd0);
        for (int i = 0; i < 40; i++) idle();
        rd(3'd0);
        check("prescale_count_40", {32'd0, bus_rdata}, 64'd10);

        for (int i = 0; i < $size(vecs); i++) begin
            drive(1'b0, vecs[i].req, vecs[i].we, vecs[i].word, vecs[i].wdata, vecs[i].be);
            check($sformatf("vec%0d_ack", i), {63'd0, bus_ack}, {63'd0, vecs[i].exp_ack});
            check($sformatf("vec%0d_rdata", i), {32'd0, bus_rdata}, {32'd0, vecs[i].exp_rdata});
        end

        // LO->HI carry and the atomic-read shadow across it.
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        idle(); idle(); idle();
        rd(3'd0);
        check("carry_lo_before", {32'd0, bus_rdata}, 64'hFFFF_FFFF);
        rd(3'd1);
        check("carry_hi_shadow", {32'd0, bus_rdata}, 64'd0);
        rd(3'd0);
        check("carry_lo_after", {32'd0, bus_rdata}, 64'd0);
        rd(3'd1);
        check("carry_hi_after", {32'd0, bus_rdata}, 64'd1);

        // Compare: irq rises one cycle after mtime reaches 20, falls two cycles after raising cmp.
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd2, 32'd20, 4'hF);
        t20 = -1;
        rise = -1;
        for (int i = 0; i < 200 && rise < 0; i++) begin
            idle();
            if (t20 < 0 && m_time == 64'd20) t20 = i;
            if (timer_irq) rise = i;
        end
        check("irq_rise_delay", 64'(rise), 64'(t20 + 1));
        wr(3'd2, 32'hFFFF_FFFF, 4'hF);
        check("irq_high_in_ack", {63'd0, timer_irq}, 64'd1);
        idle();
        check("irq_low_after", {63'd0, timer_irq}, 64'd0);

        // Back-to-back reads, then reset drops a pending access.
        rd(3'd0);
        check("b2b_ack0", {63'd0, bus_ack}, 64'd1);
        rd(3'd1);
        check("b2b_ack1", {63'd0, bus_ack}, 64'd1);
        rd(3'd6);
        check("b2b_ack6", {63'd0, bus_ack}, 64'd1);
        check("b2b_word6", {32'd0, bus_rdata}, 64'd0);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 32'd0, 4'd0);
        check("rst_drop_ack", {63'd0, bus_ack}, 64'd0);
        idle();
        check("rst_no_ack", {63'd0, bus_ack}, 64'd0);
        rd(3'd2);
        check("rst_cmp_lo", {32'd0, bus_rdata}, 64'hFFFF_FFFF);

        // Randomized traffic against the model.
        wr(3'd3, 32'h0, 4'hF);
        for (int i = 0; i < 1500; i++) begin
            logic [2:0]  w;
            logic [31:0] d;
            w = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64));
            if ($urandom_range(0, 299) == 0)
                drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
            else if ($urandom_range(0, 1) == 0)
                idle();
            else
                drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), w, d, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/machine_timer.md
# machine_timer

Memory-mapped RISC-V machine timer (mtime/mtimecmp) for the core's M-mode interrupt path. It keeps a 64-bit free-running time counter with a programmable prescaler and compares it against a 64-bit compare register. It raises `timer_irq`, which the trap/interrupt logic gates with `mie_mtie` and `mstatus_mie` from the CSR regfile to produce trap cause 0x8000_0007. Software reaches it through a simple single-cycle request/ack data-bus port.

## Interface
Parameters:
- `PRESCALE`, default 1: clock cycles per mtime increment. Legal range is 1..65535; 1 means increment every enabled cycle.

Ports. Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `bus_req`  in  1  access request, valid for one cycle per access.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  5  byte offset; `[4:2]` selects the word, `[1:0]` are ignored.
- `bus_wdata`  in  32  write data.
- `bus_be`  in  4  byte enables for writes.
- `bus_rdata`  out  32  read data, valid while `bus_ack`=1.
- `bus_ack`  out  1  access complete.
- `timer_irq`  out  1  level machine-timer interrupt pending (MTIP).

## Operation
Register map, by word index `bus_addr[4:2]`:
- 0 `MTIME_LO`, RW.
- 1 `MTIME_HI`, RW.
- 2 `MTIMECMP_LO`, RW.
- 3 `MTIMECMP_HI`, RW.
- 4 `CTRL`: bit0 `EN` is RW; bit1 `MTIP` is RO and mirrors `timer_irq`; other bits read 0.
- 5..7: read 0, writes ignored, still acked.

Reset values:
- mtime = 0.
- mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, so no interrupt after reset.
- `EN` = 1.
- Prescaler count = 0.
- `bus_ack` = 0, `bus_rdata` = 0, `timer_irq` = 0.

Prescaler and counting:
- While `EN`=1, the prescaler counts 0..PRESCALE-1.
- On the cycle the count equals PRESCALE-1, it wraps to 0 and mtime increments by 1.
- While `EN`=0, both the prescaler and mtime hold.
- mtime wraps from 2^64-1 to 0; the carry from LO to HI is internal and never split.

Writes:
- Only byte lanes with `bus_be[i]`=1 update; the other bytes of the word are kept.
- Writing one half of mtime or mtimecmp leaves the other half unchanged.
- A write to `MTIME_LO` or `MTIME_HI` also clears the prescaler count to 0.

Atomic 64-bit read:
- Reading `MTIME_LO` captures mtime[63:32] into a shadow register in the same cycle.
- A later read of `MTIME_HI` returns the shadow value, not the live value.
- Any write to mtime reloads the shadow with the new HI value.
- The shadow resets to 0.

Compare:
- `timer_irq` is registered: `timer_irq <= (mtime >= mtimecmp)`, an unsigned 64-bit compare on the current register values.
- It stays high until software raises mtimecmp or lowers mtime.
- It is not affected by `EN`.

## Timing
- Bus latency: exactly 1 cycle. `bus_req` in cycle N gives `bus_ack`=1 in N+1.
- For reads, `bus_rdata` is valid in N+1.
- Back-to-back requests on consecutive cycles are accepted, one ack per request, with no stall.
- When `bus_ack`=0, `bus_rdata` = 0.
- Write data takes effect at the end of cycle N; a read issued in N+1 returns the new value.
- `timer_irq` goes high 1 cycle after the cycle in which mtime ≥ mtimecmp first holds in the registers.
- It goes low 1 cycle after a clearing write lands (observed high during the ack cycle, low in N+2).
- Write to mtime in the same cycle as a prescaler tick: the written value wins, with no increment that cycle and the prescaler cleared.
- Write to `CTRL.EN`=0 on a tick cycle: that tick still applies, and counting stops from the next cycle.
- Reads of mtime return the register value at the start of cycle N, i.e. before any increment in N.
- Reset asserted mid-operation: on the next edge all state returns to reset values, and any pending ack is dropped (`bus_ack`=0).

## Test plan
- Reset → `bus_ack`=0, `timer_irq`=0; reads return mtime ≈ 0, mtimecmp = FFFF_FFFF/FFFF_FFFF, CTRL = 0x1.
- PRESCALE=4, 40 cycles after reset → `MTIME_LO` reads 10.
- Write `MTIME_LO`=FFFF_FFFF and `MTIME_HI`=0, then let one tick elapse → LO=0, HI=1. Read LO while HI changes → the HI read returns the shadow.
- `MTIMECMP_HI`=0, `MTIMECMP_LO`=20 → `timer_irq` rises exactly 1 cycle after mtime reaches 20. Write `MTIMECMP_LO`=FFFF_FFFF → irq falls 2 cycles after the write request.
- Write `MTIME_LO`=0x1234_5678 with `bus_be`=4'b0011 over an old value of 0xAAAA_AAAA → 0xAAAA_5678, prescaler cleared.
- Back-to-back reads of words 0 and 1, then word 6 → acks in 3 consecutive cycles, word 6 returns 0; assert `rst` mid-sequence → no further acks.
